cache_miss_ctrl: RTL and testbench

- Sequencing controller for the 1MB 4-way 32B-line cache: it owns the request lifecycle (accept, lookup, hit update, dirty-victim writeback, line fill, replay).
- Drives the array write strobes (data/tag/valid/dirty/LRU), the fill-mux select, and the main-memory read/write handshake.
- Supplies rd_valid and a stall (busy) back to the PE/TB; sits between the PE interface, the cache datapath and main memory.

---
 rtl/cache_miss_ctrl.sv | 178 +++++++++++++++++
 tb/tb_cache_miss_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_ctrl.sv
`timescale 1ns/1ps
// Request sequencer for the 4-way 32B-line cache: lookup, hit update,
// dirty-victim writeback, line fill and replay against main memory.
module cache_miss_ctrl #(
  parameter int TAG_BITS   = 14,
  parameter int IDX_BITS   = 13,
  parameter int MM_TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pe_read,
  input  logic                pe_write,
  input  logic [31:0]         pe_a,
  output logic                busy,
  output logic                rd_valid,
  input  logic                req_hit,
  input  logic                victim_mod,
  input  logic [TAG_BITS-1:0] victim_tag,
  output logic                ary_write,
  output logic                tag_write,
  output logic                val_write,
  output logic                mod_write,
  output logic                lru_write,
  output logic                is_val,
  output logic                is_mod,
  output logic                fill,
  output logic [31:0]         mm_a,
  output logic                mm_read,
  output logic                mm_write,
  input  logic                mm_waitrequest,
  input  logic                mm_readdata_valid,
  output logic                err
);

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB_REQ, FILL_REQ, FILL_WAIT, FILL_WRITE, REPLAY
  } state_t;

  state_t              state_q, state_d;
  logic [TAG_BITS-1:0] tag_q, tag_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic                wr_q, wr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         mm_a_q, mm_a_d;
  logic                err_q, err_d;
  logic                take;

  assign take = pe_read | pe_write;
  assign mm_a = mm_a_q;
  assign err  = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mm_a_q  <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mm_a_q  <= mm_a_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
    end
  end

  // Request address needs no reset: it is only consumed after an accept.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    idx_q <= idx_d;
  end

  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    mm_a_d    = mm_a_q;
    err_d     = err_q;
    busy      = 1'b1;
    rd_valid  = 1'b0;
    ary_write = 1'b0;
    tag_write = 1'b0;
    val_write = 1'b0;
    mod_write = 1'b0;
    lru_write = 1'b0;
    is_val    = 1'b0;
    is_mod    = 1'b0;
    fill      = 1'b0;
    mm_read   = 1'b0;
    mm_write  = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (take) begin
          tag_d   = pe_a[5+IDX_BITS +: TAG_BITS];
          idx_d   = pe_a[5 +: IDX_BITS];
          wr_d    = pe_write;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (req_hit) begin
          busy      = 1'b0;
          lru_write = 1'b1;
          if (wr_q) begin
            ary_write = 1'b1;
            mod_write = 1'b1;
            is_mod    = 1'b1;
          end else begin
            rd_valid  = 1'b1;
          end
          // A hit frees the controller in the same cycle, so chain the next request.
          if (take) begin
            tag_d   = pe_a[5+IDX_BITS +: TAG_BITS];
            idx_d   = pe_a[5 +: IDX_BITS];
            wr_d    = pe_write;
            state_d = LOOKUP;
          end else begin
            state_d = IDLE;
          end
        end else if (victim_mod) begin
          mm_a_d  = {victim_tag, idx_q, 5'b0};
          state_d = WB_REQ;
        end else begin
          mm_a_d  = {tag_q, idx_q, 5'b0};
          state_d = FILL_REQ;
        end
      end
      WB_REQ: begin
        mm_write = 1'b1;
        if (!mm_waitrequest) begin
          mm_a_d  = {tag_q, idx_q, 5'b0};
          state_d = FILL_REQ;
        end
      end
      FILL_REQ: begin
        mm_read = 1'b1;
        if (!mm_waitrequest) begin
          cnt_d   = '0;
          state_d = FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        if (mm_readdata_valid) begin
          state_d = FILL_WRITE;
        end else if (cnt_q == CNT_W'(MM_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FILL_WRITE: begin
        fill      = 1'b1;
        ary_write = 1'b1;
        tag_write = 1'b1;
        val_write = 1'b1;
        is_val    = 1'b1;
        mod_write = 1'b1;
        lru_write = 1'b1;
        state_d   = REPLAY;
      end
      REPLAY: begin
        state_d = LOOKUP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
`timescale 1ns/1ps
// Bench for cache_miss_ctrl: transactions are expanded into per-cycle
// stimulus/expected-output records by a transaction-level model, then replayed.
module tb_cache_miss_ctrl;

  localparam int TMO = 40;

  localparam int B_BUSY = 12, B_RDV = 11, B_ARY = 10, B_TAG = 9, B_VAL = 8,
                 B_MOD = 7, B_LRU = 6, B_ISV = 5, B_ISM = 4, B_FILL = 3,
                 B_MMR = 2, B_MMW = 1, B_ERR = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pe_read = 1'b0, pe_write = 1'b0;
  logic [31:0] pe_a = '0;
  logic        busy, rd_valid;
  logic        req_hit = 1'b0, victim_mod = 1'b0;
  logic [13:0] victim_tag = '0;
  logic        ary_write, tag_write, val_write, mod_write, lru_write;
  logic        is_val, is_mod, fill;
  logic [31:0] mm_a;
  logic        mm_read, mm_write;
  logic        mm_waitrequest = 1'b0, mm_readdata_valid = 1'b0;
  logic        err;

  always #5 clk = ~clk;

  cache_miss_ctrl #(.TAG_BITS(14), .IDX_BITS(13), .MM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .pe_read(pe_read), .pe_write(pe_write), .pe_a(pe_a),
    .busy(busy), .rd_valid(rd_valid), .req_hit(req_hit), .victim_mod(victim_mod),
    .victim_tag(victim_tag), .ary_write(ary_write), .tag_write(tag_write),
    .val_write(val_write), .mod_write(mod_write), .lru_write(lru_write),
    .is_val(is_val), .is_mod(is_mod), .fill(fill), .mm_a(mm_a),
    .mm_read(mm_read), .mm_write(mm_write), .mm_waitrequest(mm_waitrequest),
    .mm_readdata_valid(mm_readdata_valid), .err(err)
  );

  typedef struct {
    logic        rst, rd, wr;
    logic [31:0] a;
    logic        hit, vmod;
    logic [13:0] vtag;
    logic        wreq, rdv;
    logic [12:0] eo;
    logic [31:0] ea;
    bit          mark;
    int          elat;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    bit          hit, dirty;
    logic [13:0] vt;
    int          wwb, wfill, lat, elat;
  } dir_t;

  vec_t        q[$];
  dir_t        dirs[6];
  logic [31:0] m_mma;
  bit          m_err, last_hit, noisy;
  int          tests = 0, fails = 0;

  function automatic vec_t blank(input bit bsy);
    vec_t v;
    v.rst  = 1'b0; v.rd = 1'b0; v.wr = 1'b0;
    v.a    = noisy ? $urandom : 32'h0;
    v.hit  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    v.vmod = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    v.vtag = noisy ? 14'($urandom) : 14'h0;
    v.wreq = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    v.rdv  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    v.eo   = '0;
    v.eo[B_BUSY] = bsy;
    v.eo[B_ERR]  = m_err;
    v.ea   = m_mma;
    v.mark = 1'b0;
    v.elat = 0;
    return v;
  endfunction

  function automatic vec_t hit_vec(input bit wr);
    vec_t v = blank(1'b0);
    v.hit = 1'b1;
    v.eo[B_LRU] = 1'b1;
    if (wr) begin
      v.eo[B_ARY] = 1'b1; v.eo[B_MOD] = 1'b1; v.eo[B_ISM] = 1'b1;
    end else begin
      v.eo[B_RDV] = 1'b1;
    end
    return v;
  endfunction

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) q.push_back(blank(1'b0));
    last_hit = 1'b0;
  endtask

  // lat: FILL_WAIT cycles with data on the last; 0 = never (timeout); <0 = stop in FILL_WAIT
  task automatic add_txn(input bit wr, input logic [31:0] a, input bit hit, input bit dirty,
                         input logic [13:0] vt, input int wwb, input int wfill,
                         input int lat, input bit b2b, input int elat);
    vec_t v;
    logic [12:0] idx;
    logic [13:0] tg;
    idx = a[17:5];
    tg  = a[31:18];
    if (b2b && last_hit) v = q.pop_back();
    else                 v = blank(1'b0);
    v.wr = wr;
    v.rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    v.a  = a;
    v.mark = (elat != 0);
    v.elat = elat;
    q.push_back(v);
    last_hit = 1'b0;
    if (hit) begin
      q.push_back(hit_vec(wr));
      last_hit = 1'b1;
      return;
    end
    v = blank(1'b1);
    v.hit = 1'b0; v.vmod = dirty; v.vtag = vt;
    q.push_back(v);
    if (dirty) begin
      m_mma = {vt, idx, 5'b0};
      for (int i = 0; i <= wwb; i++) begin
        v = blank(1'b1);
        v.wreq = (i < wwb);
        v.eo[B_MMW] = 1'b1;
        q.push_back(v);
      end
    end
    m_mma = {tg, idx, 5'b0};
    for (int i = 0; i <= wfill; i++) begin
      v = blank(1'b1);
      v.wreq = (i < wfill);
      v.eo[B_MMR] = 1'b1;
      q.push_back(v);
    end
    if (lat < 0) begin
      for (int i = 0; i < -lat; i++) begin
        v = blank(1'b1); v.rdv = 1'b0; q.push_back(v);
      end
      return;
    end
    if (lat == 0) begin
      for (int i = 0; i < TMO; i++) begin
        v = blank(1'b1); v.rdv = 1'b0; q.push_back(v);
      end
      m_err = 1'b1;
      return;
    end
    for (int i = 1; i <= lat; i++) begin
      v = blank(1'b1); v.rdv = (i == lat); q.push_back(v);
    end
    v = blank(1'b1);
    v.eo[B_FILL] = 1'b1; v.eo[B_ARY] = 1'b1; v.eo[B_TAG] = 1'b1; v.eo[B_VAL] = 1'b1;
    v.eo[B_ISV]  = 1'b1; v.eo[B_MOD] = 1'b1; v.eo[B_LRU] = 1'b1;
    q.push_back(v);
    q.push_back(blank(1'b1));
    q.push_back(hit_vec(wr));
    last_hit = 1'b1;
  endtask

  initial begin
    vec_t v;
    logic [12:0] got;
    bit   pend;
    int   start, want;
    noisy = 1'b0; m_mma = '0; m_err = 1'b0; last_hit = 1'b0;
    pend = 1'b0; start = 0; want = 0;

    dirs[0] = '{1'b0, 32'h0004_0020, 1'b1, 1'b0, 14'h0,    0, 0, 0, 1};
    dirs[1] = '{1'b0, 32'h1234_5660, 1'b0, 1'b0, 14'h0,    0, 0, 4, 9};
    dirs[2] = '{1'b0, 32'h1234_5660, 1'b0, 1'b1, 14'h2AAA, 3, 3, 2, 14};
    dirs[3] = '{1'b1, 32'hCAFE_0040, 1'b0, 1'b1, 14'h1555, 1, 0, 1, 0};
    dirs[4] = '{1'b0, 32'h0000_1000, 1'b0, 1'b0, 14'h0,    0, 1, 0, 0};
    dirs[5] = '{1'b0, 32'h0004_0020, 1'b1, 1'b0, 14'h0,    0, 0, 0, 1};

    add_idle(2);
    for (int k = 0; k < 6; k++) begin
      add_txn(dirs[k].wr, dirs[k].a, dirs[k].hit, dirs[k].dirty, dirs[k].vt,
              dirs[k].wwb, dirs[k].wfill, dirs[k].lat, 1'b0, dirs[k].elat);
      add_idle(1);
    end

    // three chained write hits
    add_txn(1'b1, 32'h0000_0100, 1'b1, 1'b0, 14'h0, 0, 0, 0, 1'b0, 0);
    add_txn(1'b1, 32'h0000_0120, 1'b1, 1'b0, 14'h0, 0, 0, 0, 1'b1, 0);
    add_txn(1'b1, 32'h0000_0140, 1'b1, 1'b0, 14'h0, 0, 0, 0, 1'b1, 0);
    add_idle(1);

    // reset while waiting for fill data, then a stale data-valid
    add_txn(1'b0, 32'h0ABC_DE00, 1'b0, 1'b0, 14'h0, 0, 0, -3, 1'b0, 0);
    v = blank(1'b1); v.rst = 1'b1; q.push_back(v);
    m_mma = '0; m_err = 1'b0;
    v = blank(1'b0); v.rdv = 1'b1; q.push_back(v);
    add_idle(2);
    add_txn(1'b0, 32'h1234_5660, 1'b0, 1'b0, 14'h0, 0, 0, 2, 1'b0, 7);
    add_idle(1);

    noisy = 1'b1;
    for (int k = 0; k < 60; k++) begin
      int  lat;
      bit  b2b;
      lat = ($urandom_range(0, 14) == 0) ? 0 : int'($urandom_range(1, 6));
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) add_idle($urandom_range(0, 2));
      add_txn(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 14'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 3), lat, b2b, 0);
    end
    add_idle(2);

    repeat (3) @(posedge clk);
    for (int i = 0; i < q.size(); i++) begin
      v = q[i];
      @(posedge clk); #1;
      reset = v.rst; pe_read = v.rd; pe_write = v.wr; pe_a = v.a;
      req_hit = v.hit; victim_mod = v.vmod; victim_tag = v.vtag;
      mm_waitrequest = v.wreq; mm_readdata_valid = v.rdv;
      @(negedge clk);
      got = {busy, rd_valid, ary_write, tag_write, val_write, mod_write, lru_write,
             is_val, is_mod, fill, mm_read, mm_write, err};
      tests++;
      if (got !== v.eo) begin
        fails++;
        $display("FAIL vec%0d ctrl: got %b expected %b", i, got, v.eo);
      end
      tests++;
      if (mm_a !== v.ea) begin
        fails++;
        $display("FAIL vec%0d mm_a: got %h expected %h", i, mm_a, v.ea);
      end
      if (v.mark) begin
        pend = 1'b1; start = i; want = v.elat;
      end else if (pend && i == start + want) begin
        tests++;
        if (rd_valid !== 1'b1) begin
          fails++;
          $display("FAIL vec%0d rd_latency: rd_valid %b at cycle %0d, expected 1", i, rd_valid, want);
        end
        pend = 1'b0;
      end
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
